// File: rtl/uart_matrix_loader.sv
// Frame controller: hunts SYNC_BYTE, parses DIM, streams row-major elements into the operand
// buffer and hands the frame to the core with valid/ack. Trailing XOR check under MATLOAD_CHECKSUM_EN.
module uart_matrix_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_DIM        = 5,
    parameter int         ADDR_W         = 5,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              frame_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [3:0]        mat_rows,
    output logic [3:0]        mat_cols,
    output logic              frame_valid,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       MAX_DIM_L = 4'(MAX_DIM);

    localparam logic [1:0] ERR_DIM  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DIM  = 3'd1,
        ST_DATA = 3'd2,
`ifdef MATLOAD_CHECKSUM_EN
        ST_CSUM = 3'd3,
`endif
        ST_DONE = 3'd4
    } state_t;

    function automatic logic dim_legal(input logic [3:0] rows, input logic [3:0] cols);
        return (rows != 4'd0) && (rows <= MAX_DIM_L) && (cols != 4'd0) && (cols <= MAX_DIM_L);
    endfunction

`ifdef MATLOAD_CHECKSUM_EN
    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction
`endif

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   elem_cnt_r;
    logic [ADDR_W-1:0]   last_idx_r;
    logic [TMO_W-1:0]    tmo_cnt_r;
    logic [3:0]          mat_rows_r;
    logic [3:0]          mat_cols_r;
`ifdef MATLOAD_CHECKSUM_EN
    logic [7:0]          csum_r;
    logic                csum_ok_s;
`endif

    logic                wr_en_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [7:0]          wr_data_r;
    logic                frame_valid_r;
    logic                frame_err_r;
    logic [1:0]          err_code_r;
    logic                busy_r;

    logic                wr_en_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [7:0]          wr_data_s;
    logic                frame_valid_s;
    logic                err_s;
    logic [1:0]          err_code_s;
    logic                busy_s;

    logic                dim_ok_s;
    logic                dim_accept_s;
    logic                in_frame_s;
    logic                tmo_hit_s;
    logic                last_elem_s;
    logic [ADDR_W-1:0]   dim_last_idx_s;

    assign dim_ok_s       = dim_legal(rx_data[7:4], rx_data[3:0]);
    assign dim_accept_s   = (state_r == ST_DIM) && rx_valid && dim_ok_s;
    assign dim_last_idx_s = ADDR_W'(rx_data[7:4]) * ADDR_W'(rx_data[3:0]) - ADDR_W'(1);
    assign last_elem_s    = (elem_cnt_r == last_idx_r);
`ifdef MATLOAD_CHECKSUM_EN
    assign in_frame_s = (state_r == ST_DIM) || (state_r == ST_DATA) || (state_r == ST_CSUM);
    assign csum_ok_s  = (rx_data == csum_r);
`else
    assign in_frame_s = (state_r == ST_DIM) || (state_r == ST_DATA);
`endif
    // An arriving byte on the terminal count beats the timeout.
    assign tmo_hit_s = in_frame_s && !rx_valid && (tmo_cnt_r == TMO_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) state_s = ST_DIM;
                else                                    state_s = ST_IDLE;
            end
            ST_DIM: begin
                if (tmo_hit_s)     state_s = ST_IDLE;
                else if (rx_valid) state_s = dim_ok_s ? ST_DATA : ST_IDLE;
                else               state_s = ST_DIM;
            end
            ST_DATA: begin
                if (tmo_hit_s) begin
                    state_s = ST_IDLE;
                end else if (rx_valid && last_elem_s) begin
`ifdef MATLOAD_CHECKSUM_EN
                    state_s = ST_CSUM;
`else
                    state_s = ST_DONE;
`endif
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef MATLOAD_CHECKSUM_EN
            ST_CSUM: begin
                if (tmo_hit_s)     state_s = ST_IDLE;
                else if (rx_valid) state_s = csum_ok_s ? ST_DONE : ST_IDLE;
                else               state_s = ST_CSUM;
            end
`endif
            ST_DONE: begin
                if (frame_ack) state_s = ST_IDLE;
                else           state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        wr_en_s       = (state_r == ST_DATA) && rx_valid;
        wr_addr_s     = wr_addr_r;
        wr_data_s     = wr_data_r;
        frame_valid_s = (state_s == ST_DONE);
        busy_s        = (state_s != ST_IDLE);
        err_s         = 1'b0;
        err_code_s    = err_code_r;
        if (wr_en_s) begin
            wr_addr_s = elem_cnt_r;
            wr_data_s = rx_data;
        end else begin
            wr_addr_s = wr_addr_r;
            wr_data_s = wr_data_r;
        end
        if (tmo_hit_s) begin
            err_s      = 1'b1;
            err_code_s = ERR_TMO;
        end else if ((state_r == ST_DIM) && rx_valid && !dim_ok_s) begin
            err_s      = 1'b1;
            err_code_s = ERR_DIM;
`ifdef MATLOAD_CHECKSUM_EN
        end else if ((state_r == ST_CSUM) && rx_valid && !csum_ok_s) begin
            err_s      = 1'b1;
            err_code_s = ERR_CSUM;
`endif
        end else begin
            err_s      = 1'b0;
            err_code_s = err_code_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_r       <= 1'b0;
            wr_addr_r     <= '0;
            wr_data_r     <= 8'h00;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            err_code_r    <= 2'b00;
            busy_r        <= 1'b0;
        end else begin
            wr_en_r       <= wr_en_s;
            wr_addr_r     <= wr_addr_s;
            wr_data_r     <= wr_data_s;
            frame_valid_r <= frame_valid_s;
            frame_err_r   <= err_s;
            err_code_r    <= err_code_s;
            busy_r        <= busy_s;
        end
    end

    // Frame geometry, element counter and inter-byte timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            elem_cnt_r <= '0;
            last_idx_r <= '0;
            mat_rows_r <= 4'd0;
            mat_cols_r <= 4'd0;
            tmo_cnt_r  <= '0;
        end else begin
            if (dim_accept_s) begin
                elem_cnt_r <= '0;
                last_idx_r <= dim_last_idx_s;
                mat_rows_r <= rx_data[7:4];
                mat_cols_r <= rx_data[3:0];
            end else if (wr_en_s) begin
                elem_cnt_r <= elem_cnt_r + ADDR_W'(1);
            end else begin
                elem_cnt_r <= elem_cnt_r;
            end
            if (rx_valid || !in_frame_s || tmo_hit_s) tmo_cnt_r <= '0;
            else                                      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end

`ifdef MATLOAD_CHECKSUM_EN
    // Running XOR seeded with the DIM byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_r <= 8'h00;
        end else if (dim_accept_s) begin
            csum_r <= rx_data;
        end else if (wr_en_s) begin
            csum_r <= csum_fold(csum_r, rx_data);
        end else begin
            csum_r <= csum_r;
        end
    end
`endif

    assign wr_en       = wr_en_r;
    assign wr_addr     = wr_addr_r;
    assign wr_data     = wr_data_r;
    assign mat_rows    = mat_rows_r;
    assign mat_cols    = mat_cols_r;
    assign frame_valid = frame_valid_r;
    assign frame_err   = frame_err_r;
    assign err_code    = err_code_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Randomized bench for uart_matrix_loader: frames are built by the bench, and the expected
// buffer writes, error codes and handshake timing follow from the frame contents alone.
module tb_uart_matrix_loader;

    localparam int ADDR_W = 5;
    localparam int TMO    = 100;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              frame_ack;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [3:0]        mat_rows;
    logic [3:0]        mat_cols;
    logic              frame_valid;
    logic              frame_err;
    logic [1:0]        err_code;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] wr_q[$];
    logic [15:0] exp_w[$];
    logic [1:0]  err_q[$];

    uart_matrix_loader #(
        .SYNC_BYTE(8'hA5), .MAX_DIM(5), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_ack(frame_ack), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mat_rows(mat_rows), .mat_cols(mat_cols), .frame_valid(frame_valid),
        .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    // Record every buffer write and error pulse away from the active edge.
    always @(negedge clk) begin
        if (wr_en) wr_q.push_back({3'b000, wr_addr, wr_data});
        if (frame_err) err_q.push_back(err_code);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Byte lands in the (gap+1)-th cycle from now; returns 1ns into the following cycle.
    task automatic send(input logic [7:0] b, input int gap);
        idle(gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_ack();
        frame_ack = 1'b1;
        @(posedge clk); #1;
        frame_ack = 1'b0;
    endtask

    task automatic cmp_writes(input string tag);
        check({tag, "_nwr"}, wr_q.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++) check(tag, wr_q[i], exp_w[i]);
        wr_q.delete();
        exp_w.delete();
    endtask

    task automatic cmp_errs(input string tag, input int n_exp, input logic [1:0] code);
        check({tag, "_nerr"}, err_q.size(), n_exp);
        if (n_exp > 0 && err_q.size() > 0) check({tag, "_code"}, err_q[0], code);
        err_q.delete();
    endtask

    task automatic good_frame(input int r, input int c, input bit fixed);
        logic [7:0] dim, b, cs;
        int n;
        dim = {4'(r), 4'(c)};
        n   = r * c;
        cs  = dim;
        send(8'hA5, $urandom_range(0, 2));
        send(dim, $urandom_range(0, 3));
        for (int i = 0; i < n; i++) begin
            b = fixed ? 8'(i + 1) : 8'($urandom);
            exp_w.push_back({3'b000, 5'(i), b});
            cs = cs ^ b;
            if (i == n - 1) check("fv_early", frame_valid, 1'b0);
            send(b, $urandom_range(0, 3));
        end
`ifdef MATLOAD_CHECKSUM_EN
        check("fv_early_csum", frame_valid, 1'b0);
        send(cs, $urandom_range(0, 3));
`endif
        check("fv_latency", frame_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r, c, k, v;
        logic [7:0] dim, b, nb;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; frame_ack = 1'b0;
        idle(3);
        check("reset_outputs", {wr_en, wr_addr, wr_data, mat_rows, mat_cols,
                                frame_valid, frame_err, err_code, busy}, 32'd0);
        rst_n = 1'b1;
        idle(2);
        check("idle_busy", busy, 1'b0);

        // Good frames with leading noise; frame 0 is the 2x3 01..06 reference.
        for (int f = 0; f < 6; f++) begin
            r = (f == 0) ? 2 : $urandom_range(1, 5);
            c = (f == 0) ? 3 : $urandom_range(1, 5);
            send(8'h00, 0);
            send(8'hFF, 0);
            for (int j = 0; j < $urandom_range(0, 3); j++) begin
                do nb = 8'($urandom); while (nb == 8'hA5);
                send(nb, $urandom_range(0, 2));
            end
            good_frame(r, c, f == 0);
            idle($urandom_range(0, 5));
            check("fv_hold", frame_valid, 1'b1);
            check("busy_done", busy, 1'b1);
            check("mat_rows", mat_rows, 4'(r));
            check("mat_cols", mat_cols, 4'(c));
            pulse_ack();
            check("fv_after_ack", frame_valid, 1'b0);
            check("busy_after_ack", busy, 1'b0);
            cmp_writes("good_wr");
            cmp_errs("good", 0, 2'b00);
        end

        // Illegal DIM: 0x60 and 0x30 first, then random illegal combinations.
        for (int t = 0; t < 5; t++) begin
            if (t == 0) dim = 8'h60;
            else if (t == 1) dim = 8'h30;
            else begin
                v = $urandom_range(5, 15);
                r = (v == 5) ? 0 : v;
                c = $urandom_range(1, 5);
                dim = ($urandom_range(0, 1) == 1) ? {4'(r), 4'(c)} : {4'(c), 4'(r)};
            end
            send(8'hA5, 0);
            send(dim, $urandom_range(0, 3));
            idle(2);
            check("bad_dim_busy", busy, 1'b0);
            check("bad_dim_code_held", err_code, 2'b01);
            cmp_writes("bad_dim_wr");
            cmp_errs("bad_dim", 1, 2'b01);
        end

`ifdef MATLOAD_CHECKSUM_EN
        // Bad checksum on a 1x1 frame.
        send(8'hA5, 0); send(8'h11, 0); send(8'h7F, 0);
        exp_w.push_back({3'b000, 5'd0, 8'h7F});
        send(8'h00, 0);
        idle(2);
        check("bad_csum_fv", frame_valid, 1'b0);
        check("bad_csum_busy", busy, 1'b0);
        cmp_writes("bad_csum_wr");
        cmp_errs("bad_csum", 1, 2'b10);
`endif

        // Timeout: the first run is A5,22,AA then silence; then random partial frames.
        for (int t = 0; t < 3; t++) begin
            r = (t == 0) ? 2 : $urandom_range(1, 5);
            c = (t == 0) ? 2 : $urandom_range(1, 5);
            k = (t == 0) ? 1 : $urandom_range(0, r * c - 1);
            send(8'hA5, 0);
            send({4'(r), 4'(c)}, 0);
            for (int i = 0; i < k; i++) begin
                b = (t == 0) ? 8'hAA : 8'($urandom);
                exp_w.push_back({3'b000, 5'(i), b});
                send(b, 0);
            end
            idle(TMO - 1);
            check("tmo_not_yet_busy", busy, 1'b1);
            check("tmo_not_yet_err", err_q.size(), 0);
            idle(3);
            check("tmo_busy", busy, 1'b0);
            cmp_writes("tmo_wr");
            cmp_errs("tmo", 1, 2'b11);
        end

        // A byte on the terminal count is accepted and the frame completes.
        send(8'hA5, 0); send(8'h22, 0);
        send(8'hAA, 0);
        send(8'hBB, TMO - 1);
        send(8'hCC, 0);
        send(8'hDD, TMO - 1);
        exp_w.push_back({3'b000, 5'd0, 8'hAA});
        exp_w.push_back({3'b000, 5'd1, 8'hBB});
        exp_w.push_back({3'b000, 5'd2, 8'hCC});
        exp_w.push_back({3'b000, 5'd3, 8'hDD});
`ifdef MATLOAD_CHECKSUM_EN
        send(8'h22 ^ 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD, TMO - 1);
`endif
        check("term_fv", frame_valid, 1'b1);
        pulse_ack();
        cmp_writes("term_wr");
        cmp_errs("term", 0, 2'b00);

        // Back-pressure: frame held 50 cycles, bytes in DONE (and with ack) are dropped.
        good_frame(1, 1, 1'b0);
        idle(50);
        send(8'hA5, 0); send(8'h11, 0); send(8'h42, 0);
        check("bp_fv_held", frame_valid, 1'b1);
        rx_data = 8'hA5; rx_valid = 1'b1; frame_ack = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; frame_ack = 1'b0;
        send(8'h11, 0); send(8'h55, 0);
        idle(2);
        check("bp_fv_cleared", frame_valid, 1'b0);
        check("bp_busy", busy, 1'b0);
        cmp_writes("bp_wr");
        good_frame($urandom_range(1, 5), $urandom_range(1, 5), 1'b0);
        pulse_ack();
        cmp_writes("bp_fresh_wr");
        cmp_errs("bp", 0, 2'b00);

        // Reset in the middle of a 3x3 frame, then a clean 3x3 reload.
        send(8'hA5, 0); send(8'h33, 0);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            exp_w.push_back({3'b000, 5'(i), b});
            send(b, 0);
        end
        rst_n = 1'b0;
        idle(2);
        check("midrst_outputs", {wr_en, wr_addr, wr_data, mat_rows, mat_cols,
                                 frame_valid, frame_err, err_code, busy}, 32'd0);
        rst_n = 1'b1;
        idle(3);
        check("midrst_busy", busy, 1'b0);
        cmp_writes("midrst_wr");
        cmp_errs("midrst", 0, 2'b00);
        good_frame(3, 3, 1'b0);
        check("reload_rows", mat_rows, 4'd3);
        pulse_ack();
        cmp_writes("reload_wr");
        cmp_errs("reload", 0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_matrix_loader.md
Name: uart_matrix_loader

Overview:
- Frame controller sitting between the UART receiver byte stream and the matrix operand buffer of the matrix calculator.
- Hunts for a sync byte, then parses a dimension byte, writes rows*cols data bytes row-major into the buffer, and optionally checks an XOR checksum.
- Presents a completed frame to the compute core with a valid/ack handshake.
- Recovers from malformed or stalled frames by means of error codes and an inter-byte timeout.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_DIM, 5, largest legal row and column count (must be 1..15).
- ADDR_W, 5, buffer address width; must satisfy 2^ADDR_W >= MAX_DIM*MAX_DIM.
- TIMEOUT_CYCLES, 1_000_000, number of idle clk cycles between bytes that aborts a frame in progress.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx_data  in  8  received byte, qualified by rx_valid
- rx_valid  in  1  one-cycle strobe for each received byte
- frame_ack  in  1  core has consumed the frame
- wr_en  out  1  buffer write strobe
- wr_addr  out  ADDR_W  linear row-major element index
- wr_data  out  8  element value
- mat_rows  out  4  row count of the current/last frame
- mat_cols  out  4  column count of the current/last frame
- frame_valid  out  1  complete frame available, held until ack
- frame_err  out  1  one-cycle error pulse
- err_code  out  2  error cause, held until the next error or reset
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs are 0 on the clk edge with rst_n=0; state IDLE; element counter, checksum and timeout counter cleared.
- Reset mid-frame aborts the frame silently: no frame_err pulse and no further writes.
- Frame format: SYNC_BYTE, DIM, then N=rows*cols data bytes, then (optionally) CSUM. DIM[7:4]=rows, DIM[3:0]=cols.
- IDLE: any byte other than SYNC_BYTE is ignored. SYNC_BYTE -> DIM.
- DIM: rows and cols must each be in 1..MAX_DIM.
  - Legal: latch mat_rows and mat_cols, clear the element counter, seed the checksum with the DIM byte, go to DATA.
  - Illegal: go to IDLE; frame_err pulses the next cycle with err_code=2'b01.
- DATA: each rx_valid byte registers wr_en=1, wr_addr=element counter and wr_data=byte on the next cycle.
  - The counter increments; the checksum XORs in the byte.
  - On the byte with counter==N-1, go to CSUM (feature on) or DONE (feature off).
- CSUM: the received byte is compared with the running XOR.
  - Equal: go to DONE.
  - Unequal: go to IDLE; frame_err pulses with err_code=2'b10.
- DONE: frame_valid=1 from the cycle after entry and held while frame_ack=0.
  - frame_ack=1 -> frame_valid=0 and state IDLE on the next edge.
  - Bytes arriving in DONE are dropped, including one arriving in the same cycle as ack. No writes occur in DONE.
- Timeout: counter cleared on every rx_valid and in IDLE/DONE; counts only in DIM/DATA/CSUM.
  - Reaching TIMEOUT_CYCLES-1 with no byte -> IDLE; frame_err pulses with err_code=2'b11.
  - If rx_valid coincides with the terminal count, the byte wins and no timeout occurs.
- A SYNC_BYTE value inside DIM/DATA/CSUM is treated as data, not as a resync.
- Latency: last data byte (or CSUM byte) strobe -> frame_valid high 1 cycle later.
- mat_rows and mat_cols are stable from DIM acceptance until the next legal DIM byte.
- wr_en is never high for more than one cycle per byte.

Optional Feature:
- Macro: MATLOAD_CHECKSUM_EN.
- Defined: CSUM state present, trailing XOR byte required, err_code 2'b10 reachable.
- Undefined: no CSUM state and no checksum register; DONE is entered directly after the last data byte; err_code 2'b10 is never produced.

Test Plan:
- Good 2x3 frame A5,23,01..06, CSUM=0x23^0x07=0x24 -> six writes, addr 0..5 with data 01..06; mat_rows=2, mat_cols=3; frame_valid 1 cycle after CSUM; ack -> frame_valid 0 and busy 0.
- Illegal DIM: A5,60 (rows 6 > MAX_DIM=5) -> no writes, frame_err pulse, err_code=01, IDLE. Same result for DIM=0x30.
- Bad checksum: 1x1 frame A5,11,7F,00 -> one write (addr 0, data 7F); frame_err with err_code=10; frame_valid stays 0.
- Timeout with TIMEOUT_CYCLES=100: A5,22,AA then silence -> after 100 idle cycles frame_err pulses with err_code=11 and busy=0. A byte exactly at the terminal cycle is accepted instead.
- Noise and back-pressure: bytes 00,FF before A5 are ignored. While frame_valid is held 50 cycles without ack, a new A5,11,.. is dropped with no writes; after ack a fresh frame is accepted normally.
- Reset mid-DATA of a 3x3 frame -> all outputs 0, no error pulse; the next complete frame loads correctly from addr 0.
